// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues in-order word reads to instruction memory,
// buffers returned words with their PC and hands them to decode; redirect flushes everything.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];
    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   buf_data [FIFO_DEPTH];
    logic [31:0]   buf_pc   [FIFO_DEPTH];

    logic          req_fire;
    logic          resp_fire;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;
    logic [31:0]   target_pc;

    // Credit counts every fetch already in flight or buffered, so a push can never overflow.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_req_addr  = pc;
    assign target_pc      = {redirect_pc[31:2], 2'b00};

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_fire = imem_resp_valid && (outstanding != '0);
    assign push      = resp_fire && (drop == '0) && !redirect_valid;
    assign pop       = instr_valid && instr_ready;

    assign instr_valid = (count != '0);
    assign instruction = instr_valid ? buf_data[rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr]   : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= START_PC;
            resp_pc     <= START_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                pc      <= target_pc;
                resp_pc <= target_pc;
                drop    <= outstanding - CW'(resp_fire);
                count   <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (resp_fire && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= imem_resp_data;
            buf_pc[wr_ptr]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: a memory model answers requests, a
// reference fetch-order model predicts the delivered stream, a monitor checks decode output.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 2;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instruction     (instruction),
        .instr_pc        (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    exp_t  sb[$];
    pend_t pend[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_due    = 0;
    int delivered   = 0;
    int mode4_hits  = 0;
    int acc_cyc     = -10;
    bit lat_arm     = 1'b0;
    bit prev_rst_drv = 1'b1;

    int rr_pct = 100;
    int ir_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    int redir_pm = 0;
    bit mode4 = 1'b0;
    bit rst_knob = 1'b1;
    int force_cyc = -1;
    logic [31:0] force_pc = 32'h0;

    logic [31:0] next_fetch = RST_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic checkOutput(input bit ok, input string name,
                               input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model update, done late in each cycle after the monitor has consumed any handshake.
    task automatic bookkeep();
        int lat;
        int due;
        if (rst) begin
            checkOutput(imem_req_valid === 1'b0, "req_valid_in_reset", 32'(imem_req_valid), 32'h0);
            sb.delete();
            next_fetch = RST_PC;
            lat_arm = 1'b1;
            return;
        end
        if (cyc == acc_cyc + 1)
            checkOutput(instr_valid === 1'b0, "latency_t1", 32'(instr_valid), 32'h0);
        if (cyc == acc_cyc + 2)
            checkOutput(instr_valid === 1'b1, "latency_t2", 32'(instr_valid), 32'h1);
        if (redirect_valid)
            checkOutput(imem_req_valid === 1'b0, "req_during_redirect", 32'(imem_req_valid), 32'h0);
        if (imem_req_valid && imem_req_ready) begin
            lat = $urandom_range(lat_max, lat_min);
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            pend.push_back('{due, imem_req_addr});
            if (!redirect_valid) begin
                checkOutput(imem_req_addr === next_fetch, "req_addr", imem_req_addr, next_fetch);
                checkOutput(sb.size() < DEPTH, "credit_limit", 32'(sb.size()), DEPTH - 1);
                sb.push_back('{next_fetch, mem_word(next_fetch)});
                next_fetch = next_fetch + 32'd4;
                if (lat_arm) begin
                    acc_cyc = cyc;
                    lat_arm = 1'b0;
                end
            end
        end
        if (redirect_valid) begin
            sb.delete();
            next_fetch = {redirect_pc[31:2], 2'b00};
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            rst = rst_knob;
            if (rst && !prev_rst_drv) begin
                #1;
                checkOutput(instr_valid === 1'b0, "rst_instr_valid", 32'(instr_valid), 32'h0);
                checkOutput(imem_req_valid === 1'b0, "rst_req_valid", 32'(imem_req_valid), 32'h0);
                checkOutput(instruction === 32'h0, "rst_instruction", instruction, 32'h0);
                checkOutput(instr_pc === 32'h0, "rst_instr_pc", instr_pc, 32'h0);
            end
            prev_rst_drv = rst;
            imem_req_ready = ($urandom_range(99) < rr_pct);
            instr_ready    = ($urandom_range(99) < ir_pct);
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
            end
            if (!rst) begin
                if (cyc == force_cyc) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = force_pc;
                end else if ($urandom_range(999) < redir_pm) begin
                    redirect_valid = 1'b1;
                    if ($urandom_range(3) == 0) redirect_pc = $urandom_range(255);
                end
                if (mode4 && imem_resp_valid && instr_valid && instr_ready) begin
                    redirect_valid = 1'b1;
                    mode4_hits++;
                end
            end
            #6;
            bookkeep();
        end
    endtask

    // Monitor: pops the scoreboard on every decode handshake and checks hold/flush behaviour.
    initial begin
        logic        prev_valid = 1'b0;
        logic        prev_ready = 1'b0;
        logic        prev_redir = 1'b0;
        logic        prev_rst   = 1'b1;
        logic [31:0] prev_instr = 32'h0;
        logic [31:0] prev_pc    = 32'h0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst && !prev_rst) begin
                if (prev_redir) begin
                    checkOutput(instr_valid === 1'b0, "flush_after_redirect", 32'(instr_valid), 32'h0);
                end else if (prev_valid && !prev_ready) begin
                    checkOutput(instr_valid === 1'b1, "hold_valid", 32'(instr_valid), 32'h1);
                    checkOutput(instruction === prev_instr, "hold_instruction", instruction, prev_instr);
                    checkOutput(instr_pc === prev_pc, "hold_pc", instr_pc, prev_pc);
                end
            end
            if (!rst && instr_valid && instr_ready) begin
                if (sb.size() == 0) begin
                    checkOutput(1'b0, "unexpected_instr", instr_pc, 32'h0);
                end else begin
                    e = sb.pop_front();
                    checkOutput(instr_pc === e.pc, "instr_pc", instr_pc, e.pc);
                    checkOutput(instruction === e.data, "instruction", instruction, e.data);
                    delivered++;
                end
            end
            prev_valid = instr_valid;
            prev_ready = instr_ready;
            prev_redir = redirect_valid;
            prev_rst   = rst;
            prev_instr = instruction;
            prev_pc    = instr_pc;
        end
    end

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        instr_ready     = 1'b0;
        #1;
        checkOutput(instr_valid === 1'b0, "init_instr_valid", 32'(instr_valid), 32'h0);
        checkOutput(imem_req_valid === 1'b0, "init_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput(instruction === 32'h0, "init_instruction", instruction, 32'h0);
        checkOutput(instr_pc === 32'h0, "init_instr_pc", instr_pc, 32'h0);
        applyStimulus(3);

        // Streaming from the reset PC, including the address wrap past 0xFFFF_FFFC.
        rst_knob = 1'b0;
        applyStimulus(20);

        // Decoder stall: buffer fills, requests stop, outputs hold.
        ir_pct = 0;
        applyStimulus(10);
        checkOutput(imem_req_valid === 1'b0, "stall_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput(instr_valid === 1'b1, "stall_instr_valid", 32'(instr_valid), 32'h1);
        ir_pct = 100;
        applyStimulus(10);

        // Redirect with fetches in flight at latency 3.
        lat_min = 3;
        lat_max = 3;
        force_cyc = cyc + 3;
        force_pc  = 32'h0000_0103;
        applyStimulus(15);

        // Redirect coinciding with a response and a decode handshake.
        rr_pct = 70; ir_pct = 60; lat_min = 1; lat_max = 3; mode4 = 1'b1;
        applyStimulus(200);
        mode4 = 1'b0;
        checkOutput(mode4_hits > 0, "redirect_coincidence_seen", 32'(mode4_hits), 32'h1);

        // Fully random traffic with occasional redirects.
        rr_pct = 60; ir_pct = 60; lat_min = 1; lat_max = 4; redir_pm = 20;
        applyStimulus(1500);

        // Reset in mid-operation; late responses arrive while requests are held off.
        redir_pm = 0; rr_pct = 100; ir_pct = 0; lat_min = 3; lat_max = 3;
        applyStimulus(3);
        rst_knob = 1'b1;
        applyStimulus(1);
        rst_knob = 1'b0; rr_pct = 0; ir_pct = 100;
        applyStimulus(8);
        rr_pct = 100; lat_min = 1; lat_max = 1;
        applyStimulus(20);

        checkOutput(delivered > 100, "delivered_count", 32'(delivered), 32'd101);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
